// File: rtl/noise_detection_pkg.sv
// Shared defaults and helpers for the impulse-noise detector.
// Imported by the comparator and by the top level so defaults stay in one place.
package noise_detection_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_WIDTH  = 16;

  // Largest unsigned value a pixel of the given width can hold.
  function automatic int unsigned maxPixel(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

  localparam int unsigned DEFAULT_MAX_PIXEL = maxPixel(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/noise_compare.sv
// Purely combinational salt/pepper classifier: a pixel at or below T1, or at or
// above T2, is treated as impulse noise.
module noise_compare
  import noise_detection_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned T1         = 0,
  parameter int unsigned T2         = maxPixel(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] pixel,
  output logic                  noisy
);

  // Reject threshold sets that would make the clean band empty or unreachable.
  if (T1 >= T2) begin : gBadOrder
    $fatal(1, "noise_compare: T1 must be strictly below T2");
  end
  if (T2 > maxPixel(DATA_WIDTH)) begin : gBadRange
    $fatal(1, "noise_compare: T2 exceeds the largest pixel value");
  end

  localparam logic [DATA_WIDTH-1:0] LO_THRESH = DATA_WIDTH'(T1);
  localparam logic [DATA_WIDTH-1:0] HI_THRESH = DATA_WIDTH'(T2);

  assign noisy = (pixel <= LO_THRESH) || (pixel >= HI_THRESH);

endmodule

// File: rtl/noise_detection.sv
// Registered impulse-noise detector: one-cycle flag per accepted centre pixel
// plus a saturating count of noisy samples.
module noise_detection
  import noise_detection_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned T1         = 0,
  parameter int unsigned T2         = maxPixel(DATA_WIDTH),
  parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] wCenter,
  input  logic                  cnt_clr,
  output logic                  noiseF,
  output logic                  out_valid,
  output logic [CNT_WIDTH-1:0]  noise_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic isNoisy;

  noise_compare #(
    .DATA_WIDTH (DATA_WIDTH),
    .T1         (T1),
    .T2         (T2)
  ) uCompare (
    .pixel (wCenter),
    .noisy (isNoisy)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      noiseF      <= 1'b0;
      out_valid   <= 1'b0;
      noise_count <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        noiseF <= isNoisy;
      end
      // Clear takes priority over a same-cycle increment; the count never wraps.
      if (cnt_clr) begin
        noise_count <= '0;
      end else if (in_valid && isNoisy && (noise_count != CNT_MAX)) begin
        noise_count <= noise_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_noise_detection.sv
// Scoreboard bench for noise_detection across three parameter sets.
module tb_noise_detection;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults. B: T1=10, T2=200. C: CNT_WIDTH=2.
  logic       validA = 1'b0, clrA = 1'b0, flagA, ovA;
  logic [7:0] pixA = '0;
  logic [15:0] cntA;
  logic       validB = 1'b0, clrB = 1'b0, flagB, ovB;
  logic [7:0] pixB = '0;
  logic [15:0] cntB;
  logic       validC = 1'b0, clrC = 1'b0, flagC, ovC;
  logic [7:0] pixC = '0;
  logic [1:0] cntC;

  noise_detection uDutA (
    .clk(clk), .rst_n(rst_n), .in_valid(validA), .wCenter(pixA), .cnt_clr(clrA),
    .noiseF(flagA), .out_valid(ovA), .noise_count(cntA)
  );

  noise_detection #(.T1(10), .T2(200)) uDutB (
    .clk(clk), .rst_n(rst_n), .in_valid(validB), .wCenter(pixB), .cnt_clr(clrB),
    .noiseF(flagB), .out_valid(ovB), .noise_count(cntB)
  );

  noise_detection #(.CNT_WIDTH(2)) uDutC (
    .clk(clk), .rst_n(rst_n), .in_valid(validC), .wCenter(pixC), .cnt_clr(clrC),
    .noiseF(flagC), .out_valid(ovC), .noise_count(cntC)
  );

  typedef struct {
    int          dut;
    logic        flag;
    logic        ov;
    int unsigned cnt;
    string       tag;
  } exp_t;

  exp_t sbq[$];

  int unsigned t1Of[3]   = '{0, 10, 0};
  int unsigned t2Of[3]   = '{255, 200, 255};
  int unsigned cmaxOf[3] = '{65535, 65535, 3};
  logic        mFlag[3];
  int unsigned mCnt[3];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mFlag[i] = 1'b0;
      mCnt[i]  = 0;
    end
  endtask

  task automatic idleInputs();
    validA = 1'b0; clrA = 1'b0;
    validB = 1'b0; clrB = 1'b0;
    validC = 1'b0; clrC = 1'b0;
  endtask

  // Drive one sample into the chosen instance, predict, then compare after the edge.
  task automatic step(input int dut, input logic v, input int unsigned pix,
                      input logic clr, input string tag);
    exp_t        e;
    exp_t        got;
    logic        nz;
    logic [7:0]  p;
    p = pix[7:0];
    case (dut)
      0:       begin validA = v; pixA = p; clrA = clr; end
      1:       begin validB = v; pixB = p; clrB = clr; end
      default: begin validC = v; pixC = p; clrC = clr; end
    endcase
    nz = (pix <= t1Of[dut]) || (pix >= t2Of[dut]);
    if (v) mFlag[dut] = nz;
    if (clr) mCnt[dut] = 0;
    else if (v && nz && (mCnt[dut] < cmaxOf[dut])) mCnt[dut] = mCnt[dut] + 1;
    e.dut = dut; e.flag = mFlag[dut]; e.ov = v; e.cnt = mCnt[dut]; e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    idleInputs();
    got = sbq.pop_front();
    case (got.dut)
      0: begin
        check({got.tag, "_flag"}, 32'(flagA), 32'(got.flag));
        check({got.tag, "_ov"},   32'(ovA),   32'(got.ov));
        check({got.tag, "_cnt"},  32'(cntA),  got.cnt);
      end
      1: begin
        check({got.tag, "_flag"}, 32'(flagB), 32'(got.flag));
        check({got.tag, "_ov"},   32'(ovB),   32'(got.ov));
        check({got.tag, "_cnt"},  32'(cntB),  got.cnt);
      end
      default: begin
        check({got.tag, "_flag"}, 32'(flagC), 32'(got.flag));
        check({got.tag, "_ov"},   32'(ovC),   32'(got.ov));
        check({got.tag, "_cnt"},  32'(cntC),  got.cnt);
      end
    endcase
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_flagA"}, 32'(flagA), 0);
    check({tag, "_ovA"},   32'(ovA),   0);
    check({tag, "_cntA"},  32'(cntA),  0);
    check({tag, "_flagB"}, 32'(flagB), 0);
    check({tag, "_cntB"},  32'(cntB),  0);
    check({tag, "_flagC"}, 32'(flagC), 0);
    check({tag, "_cntC"},  32'(cntC),  0);
  endtask

  int unsigned seqA[8] = '{14, 0, 200, 100, 255, 0, 250, 255};
  logic        expA[8] = '{0, 1, 0, 0, 1, 1, 0, 1};
  int unsigned seqB[4] = '{10, 11, 199, 200};
  logic        expB[4] = '{1, 0, 0, 1};
  int unsigned expC[5] = '{1, 2, 3, 3, 3};
  int unsigned edgePix[6] = '{0, 1, 10, 128, 254, 255};

  initial begin
    modelReset();
    // Reset held across edges with a sample presented: nothing may be accepted.
    validA = 1'b1; pixA = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    idleInputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Default thresholds, back-to-back samples.
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b1, seqA[i], 1'b0, $sformatf("seqA%0d", i));
      check($sformatf("seqA%0d_tbl", i), 32'(flagA), 32'(expA[i]));
    end
    check("seqA_total", 32'(cntA), 4);

    // Threshold boundaries at T1=10 and T2=200.
    for (int i = 0; i < 4; i++) begin
      step(1, 1'b1, seqB[i], 1'b0, $sformatf("bnd%0d", i));
      check($sformatf("bnd%0d_tbl", i), 32'(flagB), 32'(expB[i]));
    end

    // Gapped input: flag holds, valid drops, count only moves on accepted noise.
    step(0, 1'b0, 0, 1'b1, "clrA");
    step(0, 1'b1, 0, 1'b0, "gap0");
    step(0, 1'b0, 0, 1'b0, "gap1");
    step(0, 1'b1, 14, 1'b0, "gap2");
    check("gap_total", 32'(cntA), 1);

    // Two-bit counter saturates, then clear wins over a noisy sample.
    for (int i = 0; i < 5; i++) begin
      step(2, 1'b1, 255, 1'b0, $sformatf("sat%0d", i));
      check($sformatf("sat%0d_tbl", i), 32'(cntC), expC[i]);
    end
    step(2, 1'b1, 0, 1'b1, "satclr");
    check("satclr_tbl", 32'(cntC), 0);

    // Mixed random traffic across all instances.
    for (int i = 0; i < 60; i++) begin
      step(int'($urandom_range(0, 2)), 1'($urandom_range(0, 3) != 0),
           edgePix[$urandom_range(0, 5)] + ((i % 7 == 0) ? 32'($urandom_range(0, 1)) : 0),
           1'($urandom_range(0, 9) == 0), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-stream while the flag is set.
    step(0, 1'b1, 255, 1'b0, "prerst");
    check("prerst_set", 32'(flagA), 1);
    validA = 1'b1; pixA = 8'd0;
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("asyncrst");
    @(posedge clk);
    #1;
    checkAllZero("rsthold");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1'b1, 0, 1'b0, "postrst");
    check("postrst_cnt", 32'(cntA), 1);

    check("sb_empty", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
